// File: rtl/alu_writeback.sv
// Execute->writeback stage: 2-entry in-order skid buffer feeding the register-file
// write port, owner of the architectural NZCV flags. Optional perf counters: ALU_WB_PERF_EN.
module alu_writeback #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned PERF_W     = 16,
  parameter logic [4:0]  OP_ADD     = 5'd0,
  parameter logic [4:0]  OP_SUB     = 5'd1,
  parameter logic [4:0]  OP_CMP     = 5'd5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_op,
  input  logic [DATA_W-1:0]       in_result,
  input  logic [3:0]              in_nzcv,
  input  logic [REG_ADDR_W-1:0]   in_rd,
  output logic                    rf_we,
  output logic [REG_ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]       rf_wdata,
  input  logic                    rf_ready,
  output logic [3:0]              flags,
  output logic [1:0]              fwd_valid,
  output logic [2*REG_ADDR_W-1:0] fwd_rd,
  output logic [2*DATA_W-1:0]     fwd_data
`ifdef ALU_WB_PERF_EN
  ,
  output logic [PERF_W-1:0]       perf_retired,
  output logic [PERF_W-1:0]       perf_stall
`endif
);

  if (PERF_W < 1) begin : g_bad_perf_w
    $error("PERF_W must be at least 1");
  end

  // cmp: retires without writing; full: flags come from the ALU nzcv verbatim
  typedef struct packed {
    logic                  cmp;
    logic                  full;
    logic [3:0]            nzcv;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     res;
  } entry_t;

  entry_t     ent_q [2];
  entry_t     ent_d [2];
  entry_t     head;
  entry_t     new_ent;
  logic [1:0] count_q, count_d, cnt_after;
  logic [3:0] flags_q, flags_d;
  logic       head_valid, retire, accept;

  always_comb begin
    head       = ent_q[0];
    head_valid = (count_q != 2'd0);
    rf_we      = head_valid && !head.cmp;
    retire     = head_valid && (head.cmp || rf_ready);
    in_ready   = (count_q != 2'd2);
    accept     = in_valid && in_ready && !flush;
    cnt_after  = count_q - {1'b0, retire};

    new_ent.cmp  = (in_op == OP_CMP);
    new_ent.full = (in_op == OP_ADD) || (in_op == OP_SUB) || (in_op == OP_CMP);
    new_ent.nzcv = in_nzcv;
    new_ent.rd   = in_rd;
    new_ent.res  = in_result;

    ent_d   = ent_q;
    count_d = count_q;
    flags_d = flags_q;

    // A retire coinciding with flush still commits its write and flag update
    if (retire) begin
      ent_d[0] = ent_q[1];
      if (head.full) flags_d = head.nzcv;
      else           flags_d = {head.res[DATA_W-1], (head.res == '0), flags_q[1:0]};
    end

    if (flush) begin
      count_d = 2'd0;
    end else begin
      count_d = cnt_after + {1'b0, accept};
      if (accept) ent_d[cnt_after[0]] = new_ent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      flags_q  <= 4'b0000;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      flags_q  <= flags_d;
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
    end
  end

  assign rf_waddr  = rf_we ? head.rd  : '0;
  assign rf_wdata  = rf_we ? head.res : '0;
  assign flags     = flags_q;
  assign fwd_valid = {(count_q == 2'd2) && !ent_q[1].cmp, head_valid && !ent_q[0].cmp};
  assign fwd_rd    = {ent_q[1].rd, ent_q[0].rd};
  assign fwd_data  = {ent_q[1].res, ent_q[0].res};

`ifdef ALU_WB_PERF_EN
  logic [PERF_W-1:0] perf_retired_q, perf_retired_d;
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_retired_d = perf_retired_q + {{(PERF_W-1){1'b0}}, retire};
    perf_stall_d   = perf_stall_q + {{(PERF_W-1){1'b0}}, (in_valid && !in_ready)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: writes, CMP retire, backpressure ordering,
// flush and async reset. Perf counters checked when ALU_WB_PERF_EN is defined.
module tb_alu_writeback;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned RA_W   = 3;
  localparam int unsigned PERF_W = 16;
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_CMP = 5'd5;

  logic                  clk, rst_n, flush, in_valid, in_ready, rf_ready, rf_we;
  logic [4:0]            in_op;
  logic [DATA_W-1:0]     in_result, rf_wdata;
  logic [3:0]            in_nzcv, flags;
  logic [RA_W-1:0]       in_rd, rf_waddr;
  logic [1:0]            fwd_valid;
  logic [2*RA_W-1:0]     fwd_rd;
  logic [2*DATA_W-1:0]   fwd_data;
`ifdef ALU_WB_PERF_EN
  logic [PERF_W-1:0]     perf_retired, perf_stall;
`endif

  int total_cnt = 0;
  int bad_cnt   = 0;
  logic [RA_W+DATA_W-1:0] exp_q[$];

  alu_writeback #(
    .DATA_W(DATA_W), .REG_ADDR_W(RA_W), .PERF_W(PERF_W),
    .OP_ADD(OP_ADD), .OP_SUB(OP_SUB), .OP_CMP(OP_CMP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_result(in_result), .in_nzcv(in_nzcv), .in_rd(in_rd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .flags(flags), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`ifdef ALU_WB_PERF_EN
    , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [RA_W-1:0] rd,
                       input logic [DATA_W-1:0] res, input logic [3:0] nzcv);
    in_valid  = v;
    in_op     = op;
    in_rd     = rd;
    in_result = res;
    in_nzcv   = nzcv;
  endtask

  initial begin
    int  cyc;
    logic [RA_W+DATA_W-1:0] exp_w;
    rst_n = 1'b0; flush = 1'b0; rf_ready = 1'b0;
    drive(1'b0, OP_ADD, '0, '0, '0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_rf_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_flags", flags, 4'b0000);
    check("rst_fwd_valid", fwd_valid, 2'b00);

    // ADD r3 = 0, nzcv 0110
    rf_ready = 1'b1;
    drive(1'b1, OP_ADD, 3'd3, 16'h0000, 4'b0110);
    tick();
    drive(1'b0, OP_ADD, '0, '0, '0);
    check("add_rf_we", rf_we, 1);
    check("add_waddr", rf_waddr, 3);
    check("add_wdata", rf_wdata, 0);
    check("add_fwd_valid", fwd_valid, 2'b01);
    check("add_fwd_rd", fwd_rd[RA_W-1:0], 3);
    check("add_flags_early", flags, 4'b0000);
    tick();
    check("add_flags", flags, 4'b0110);
    check("add_rf_we_done", rf_we, 0);

    // CMP with rf_ready low retires anyway
    rf_ready = 1'b0;
    drive(1'b1, OP_CMP, 3'd5, 16'h1234, 4'b0011);
    tick();
    drive(1'b0, OP_ADD, '0, '0, '0);
    check("cmp_rf_we", rf_we, 0);
    check("cmp_fwd_valid", fwd_valid, 2'b00);
    check("cmp_flags_early", flags, 4'b0110);
    tick();
    check("cmp_flags", flags, 4'b0011);
    check("cmp_in_ready", in_ready, 1);
    rf_ready = 1'b1;
    drive(1'b1, OP_AND, 3'd2, 16'h8000, 4'b0000);
    tick();
    drive(1'b0, OP_ADD, '0, '0, '0);
    check("and_rf_we", rf_we, 1);
    check("and_wdata", rf_wdata, 16'h8000);
    tick();
    check("and_flags", flags, 4'b1011);

    // Backpressure: three back-to-back pushes with rf_ready low
    rf_ready = 1'b0;
    drive(1'b1, OP_ADD, 3'd1, 16'h0011, 4'b0000);
    tick();
    check("bp_in_ready1", in_ready, 1);
    drive(1'b1, OP_SUB, 3'd2, 16'h0022, 4'b0010);
    tick();
    check("bp_full", in_ready, 0);
    check("bp_fwd_valid", fwd_valid, 2'b11);
    check("bp_fwd_rd", fwd_rd, {3'd2, 3'd1});
    check("bp_fwd_data", fwd_data, {16'h0022, 16'h0011});
    drive(1'b1, OP_OR, 3'd3, 16'h0033, 4'b0000);
    tick();
    check("bp_held_ready", in_ready, 0);
    check("bp_held_waddr", rf_waddr, 1);
    exp_q.push_back({3'd1, 16'h0011});
    exp_q.push_back({3'd2, 16'h0022});
    exp_q.push_back({3'd3, 16'h0033});
    rf_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 8) begin
      logic acc;
      if (cyc == 0) check("bp_ready_stays_low", in_ready, 0);
      if (cyc == 1) check("bp_ready_rises", in_ready, 1);
      check("bp_retire_each_cycle", rf_we, 1);
      if (rf_we) begin
        exp_w = exp_q.pop_front();
        check("bp_order", {rf_waddr, rf_wdata}, exp_w);
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) drive(1'b0, OP_ADD, '0, '0, '0);
      cyc++;
    end
    check("bp_drained", exp_q.size(), 0);
    check("bp_idle", rf_we, 0);
    check("bp_flags", flags, 4'b0010);

    // Flush with full buffer: head still writes, tail and new input dropped
    rf_ready = 1'b0;
    drive(1'b1, OP_ADD, 3'd4, 16'h1234, 4'b1000);
    tick();
    drive(1'b1, OP_ADD, 3'd5, 16'h5555, 4'b0101);
    tick();
    check("fl_full", in_ready, 0);
    drive(1'b1, OP_ADD, 3'd6, 16'h6666, 4'b1111);
    flush = 1'b1;
    rf_ready = 1'b1;
    check("fl_head_waddr", rf_waddr, 4);
    tick();
    flush = 1'b0;
    drive(1'b0, OP_ADD, '0, '0, '0);
    check("fl_rf_we", rf_we, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_fwd_valid", fwd_valid, 2'b00);
    check("fl_flags", flags, 4'b1000);
    tick();
    check("fl_dropped", rf_we, 0);
    check("fl_flags_kept", flags, 4'b1000);

`ifdef ALU_WB_PERF_EN
    // retires: ADD, CMP, AND, 3 ordered, flush head = 7; stalls: 2 in backpressure + flush cycle
    check("perf_retired", perf_retired, 7);
    check("perf_stall", perf_stall, 3);
`endif

    // Async reset mid-cycle with two entries buffered
    rf_ready = 1'b0;
    drive(1'b1, OP_ADD, 3'd1, 16'h00AA, 4'b1100);
    tick();
    drive(1'b1, OP_ADD, 3'd2, 16'h00BB, 4'b1100);
    tick();
    drive(1'b0, OP_ADD, '0, '0, '0);
    check("ar_pre_rf_we", rf_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_rf_we", rf_we, 0);
    check("ar_flags", flags, 4'b0000);
    check("ar_in_ready", in_ready, 1);
    check("ar_fwd_valid", fwd_valid, 2'b00);
`ifdef ALU_WB_PERF_EN
    check("ar_perf_retired", perf_retired, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    rf_ready = 1'b1;
    tick();
    check("ar_nothing_retired", rf_we, 0);
    check("ar_flags_after", flags, 4'b0000);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  // guard against a stuck run
  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
